shifter_multicycle: RTL

SHIFTER_MULTICYCLE -- requirements
Module: shifter_multicycle

---
 rtl/shifter_multicycle_if.sv | 38 +++
 rtl/shifter_multicycle.sv | 117 +++++++++++
 2 files changed

// File: rtl/shifter_multicycle_if.sv
// Request/result handshake bundle for the multicycle shifter.
// The producer drives the request side and the consumer drives o_ready.
interface shifter_multicycle_if #(
    parameter int N = 32
);
    localparam int L = $clog2(N);

    logic         i_valid;
    logic         i_ready;
    logic [N-1:0] in;
    logic [L-1:0] shamt;
    logic [1:0]   mode;
    logic         o_valid;
    logic         o_ready;
    logic [N-1:0] out;

    modport slave (
        input  i_valid,
        input  in,
        input  shamt,
        input  mode,
        input  o_ready,
        output i_ready,
        output o_valid,
        output out
    );

    modport master (
        output i_valid,
        output in,
        output shamt,
        output mode,
        output o_ready,
        input  i_ready,
        input  o_valid,
        input  out
    );
endinterface

// File: rtl/shifter_multicycle.sv
// Barrel shifter that applies one power-of-two stage per cycle (L = log2(N) stages),
// supporting SLL, SRL, SRA and ROR with a valid/ready request and result handshake.
module shifter_multicycle #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    shifter_multicycle_if.slave  bus
);
    localparam int L = $clog2(N);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [L-1:0] k_q, k_d;
    logic [L-1:0] shamt_q, shamt_d;
    logic [1:0]   mode_q, mode_d;
    logic [N-1:0] work_q, work_d;

    logic [N-1:0] stage_res [L];
    logic [N-1:0] stage_val;

    // One candidate result per stage; stage gi shifts by a fixed 2^gi.
    // SRA keeps the MSB intact, so the working register's MSB is always the latched sign.
    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            logic [N-1:0] sll_v;
            logic [N-1:0] srl_v;
            logic [N-1:0] sra_v;
            logic [N-1:0] ror_v;

            assign sll_v = work_q << SH;
            assign srl_v = work_q >> SH;
            assign sra_v = $signed(work_q) >>> SH;
            assign ror_v = (work_q >> SH) | (work_q << (N - SH));

            assign stage_res[gi] = (mode_q == MODE_SLL) ? sll_v :
                                   (mode_q == MODE_SRL) ? srl_v :
                                   (mode_q == MODE_SRA) ? sra_v : ror_v;
        end
    endgenerate

    always_comb begin
        stage_val = work_q;
        for (int j = 0; j < L; j++) begin
            if ((k_q == L'(j)) && shamt_q[j]) begin
                stage_val = stage_res[j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        work_d  = work_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    work_d  = bus.in;
                    shamt_d = bus.shamt;
                    mode_d  = bus.mode;
                    k_d     = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_d = stage_val;
                if (k_q == L'(L - 1)) begin
                    k_d     = '0;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + L'(1);
                end
            end
            S_DONE: begin
                if (bus.o_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            shamt_q <= '0;
            mode_q  <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
        end
    end

    assign bus.i_ready = (state_q == S_IDLE);
    assign bus.o_valid = (state_q == S_DONE);
    assign bus.out     = work_q;
endmodule
